ex_alu_stage: RTL and testbench

- Execute-stage datapath directly downstream of the ALU control decoder.
- Consumes the 4-bit Operation code plus the two operands and carried control fields from the ID/EX side.
- Computes the result and registers it into an EX/MEM-facing output with a valid/ready handshake.
- A 2-entry skid buffer lets downstream stalls back-pressure without a combinational ready path.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_core.sv | 38 +++
 rtl/ex_alu_stage.sv | 111 +++++++++++
 tb/tb_ex_alu_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, shift-amount width and the
// ALU control decode used ahead of the execute stage.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLT = 4'b1100
  } alu_op_t;

  localparam int SHAMT_W = 5;

  // ALU control decode: alu_op 00 = address add, 01 = branch compare,
  // 10 = R/I-type selected by funct3 and funct7[5].
  function automatic alu_op_t alu_decode(input logic [1:0] alu_op,
                                         input logic [2:0] funct3,
                                         input logic       funct7_b5,
                                         input logic       is_rtype);
    alu_op_t op;
    op = OP_ADD;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_BEQ;
      default: begin
        case (funct3)
          3'b000:  op = (is_rtype && funct7_b5) ? OP_SUB : OP_ADD;
          3'b001:  op = OP_SLL;
          3'b010:  op = OP_SLT;
          3'b100:  op = OP_XOR;
          3'b101:  op = funct7_b5 ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          3'b111:  op = OP_AND;
          default: op = OP_ADD;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (Operation, SrcA, SrcB) -> result.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic [DATA_W-1:0] result
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt_signed;
  logic               eq;

  assign shamt     = SrcB[SHAMT_W-1:0];
  assign lt_signed = $signed(SrcA) < $signed(SrcB);
  assign eq        = (SrcA == SrcB);

  always_comb begin
    result = '0;
    case (alu_op_t'(Operation))
      OP_AND:  result = SrcA & SrcB;
      OP_OR:   result = SrcA | SrcB;
      OP_ADD:  result = SrcA + SrcB;
      OP_XOR:  result = SrcA ^ SrcB;
      OP_SLL:  result = SrcA << shamt;
      OP_SRL:  result = SrcA >> shamt;
      OP_SUB:  result = SrcA - SrcB;
      OP_SRA:  result = $unsigned($signed(SrcA) >>> shamt);
      OP_BEQ:  result = {{(DATA_W-1){1'b0}}, eq};
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, lt_signed};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU result registered behind a valid/ready handshake with a
// one-entry skid. Optional stall counter under EX_ALU_STALL_CNT_EN.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero,
  output logic [RD_W-1:0]   rd_out,
  output logic [CTRL_W-1:0] ctrl_out
`ifdef EX_ALU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [DATA_W-1:0] core_result;
  logic              core_zero;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_result;
  logic              skid_zero;
  logic [RD_W-1:0]   skid_rd;
  logic [CTRL_W-1:0] skid_ctrl;

  logic              accept;
  logic              out_free;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .result    (core_result)
  );

  assign core_zero = (core_result == '0);

  // in_ready depends only on the skid flop, never on out_ready.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      ALUResult   <= '0;
      Zero        <= 1'b0;
      rd_out      <= '0;
      ctrl_out    <= '0;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_zero   <= 1'b0;
      skid_rd     <= '0;
      skid_ctrl   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Skid is older than anything arriving now; it goes out first.
        out_valid  <= 1'b1;
        ALUResult  <= skid_result;
        Zero       <= skid_zero;
        rd_out     <= skid_rd;
        ctrl_out   <= skid_ctrl;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        ALUResult <= core_result;
        Zero      <= core_zero;
        rd_out    <= rd_in;
        ctrl_out  <= ctrl_in;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid  <= 1'b1;
      skid_result <= core_result;
      skid_zero   <= core_zero;
      skid_rd     <= rd_in;
      skid_ctrl   <= ctrl_in;
    end
  end

`ifdef EX_ALU_STALL_CNT_EN
  // Saturating; only reset clears it so flushes do not hide stall history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage (stall counter checks compile
// in only when EX_ALU_STALL_CNT_EN is defined).
module tb_ex_alu_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  rd_in;
  logic [7:0]  ctrl_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [4:0]  rd_out;
  logic [7:0]  ctrl_out;
`ifdef EX_ALU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ex_alu_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .rd_in     (rd_in),
    .ctrl_in   (ctrl_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .rd_out    (rd_out),
    .ctrl_out  (ctrl_out)
`ifdef EX_ALU_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction at the negedge, let one posedge pass, sample #1 after.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [7:0] ctrl);
    @(negedge clk);
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    rd_in     = rd;
    ctrl_in   = ctrl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; Operation = '0; SrcA = '0; SrcB = '0;
    rd_in = '0; ctrl_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd0);
    check("rst_rd_ctrl", {19'd0, rd_out, ctrl_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic ops, output always drained
    send(4'b0010, 32'd5, 32'd7, 5'd3, 8'hA5);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", ALUResult, 32'd12);
    check("add_zero", {31'd0, Zero}, 32'd0);
    check("add_rd", {27'd0, rd_out}, 32'd3);
    check("add_ctrl", {24'd0, ctrl_out}, 32'hA5);
    send(4'b0110, 32'd7, 32'd7, 5'd4, 8'h01);
    check("sub_result", ALUResult, 32'd0);
    check("sub_zero", {31'd0, Zero}, 32'd1);
    send(4'b0111, 32'h8000_0000, 32'd4, 5'd1, 8'h00);
    check("sra_result", ALUResult, 32'hF800_0000);
    send(4'b0101, 32'h8000_0000, 32'd4, 5'd1, 8'h00);
    check("srl_result", ALUResult, 32'h0800_0000);
    send(4'b1100, 32'hFFFF_FFFF, 32'd1, 5'd1, 8'h00);
    check("slt_result", ALUResult, 32'd1);
    send(4'b1100, 32'd1, 32'hFFFF_FFFF, 5'd1, 8'h00);
    check("slt_false", ALUResult, 32'd0);
    send(4'b1000, 32'd9, 32'd9, 5'd1, 8'h00);
    check("beq_result", ALUResult, 32'd1);
    send(4'b1111, 32'd9, 32'd9, 5'd1, 8'h00);
    check("bad_op_result", ALUResult, 32'd0);
    check("bad_op_zero", {31'd0, Zero}, 32'd1);
    send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd1, 8'h00);
    check("and_result", ALUResult, 32'h00F0_1234);
    send(4'b0001, 32'hF000_0001, 32'h0000_0010, 5'd1, 8'h00);
    check("or_result", ALUResult, 32'hF000_0011);
    send(4'b0011, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd1, 8'h00);
    check("xor_result", ALUResult, 32'hF0F0_0F0F);
    send(4'b0100, 32'd1, 32'h0000_0123, 5'd1, 8'h00);
    check("sll_shamt5", ALUResult, 32'h0000_0008);
    send(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd1, 8'h00);
    check("add_wrap", ALUResult, 32'd0);
    idle_cycle();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: three back-to-back inputs with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd1, 5'd11, 8'h00);
    check("bp1_in_ready", {31'd0, in_ready}, 32'd1);
    send(4'b0010, 32'd2, 32'd2, 5'd12, 8'h00);
    check("bp2_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp2_result", ALUResult, 32'd2);
    @(negedge clk);
    in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd3; SrcB = 32'd3; rd_in = 5'd13;
    @(posedge clk); #1;
    check("bp3_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp3_hold_result", ALUResult, 32'd2);
    check("bp3_hold_rd", {27'd0, rd_out}, 32'd11);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rel1_result", ALUResult, 32'd4);
    check("rel1_rd", {27'd0, rd_out}, 32'd12);
    check("rel1_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rel2_valid", {31'd0, out_valid}, 32'd1);
    check("rel2_result", ALUResult, 32'd6);
    check("rel2_rd", {27'd0, rd_out}, 32'd13);
    idle_cycle();
    check("rel3_empty", {31'd0, out_valid}, 32'd0);

    // Flush with a full buffer and a live input
    @(negedge clk);
    out_ready = 1'b0;
    send(4'b0010, 32'd10, 32'd0, 5'd1, 8'h00);
    send(4'b0010, 32'd20, 32'd0, 5'd2, 8'h00);
    check("fl_full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1; SrcA = 32'd99; SrcB = 32'd0; flush = 1'b1;
    @(posedge clk); #1;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fl_nothing_out", {31'd0, out_valid}, 32'd0);

    // Async reset while full
    @(negedge clk);
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd2, 5'd5, 8'h33);
    send(4'b0010, 32'd3, 32'd4, 5'd6, 8'h44);
    check("ar_full_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_result", ALUResult, 32'd0);
    check("ar_rd_ctrl", {19'd0, rd_out, ctrl_out}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Stall accounting: 10 cycles of in_valid with out_ready low
    @(negedge clk);
    in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd0; out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("st_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef EX_ALU_STALL_CNT_EN
    check("st_count", {16'd0, stall_cnt}, 32'd8);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("st_flush_keeps", {16'd0, stall_cnt}, 32'd8);
`endif
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

endmodule
